uart_echo_buffer: RTL and testbench
===================================

Name: uart_echo_buffer

Overview:
- Buffered, parametrised successor to the direct rx-to-tx loopback.
- Sits between a uart_rx instance and a uart_tx instance.
- Queues received words in a FIFO and drains them to the transmitter under a busy-aware handshake FSM.
- Adds run-time modes (echo, hold, discard), overflow detection, BREAK-triggered flush and a tx-start timeout.

Parameters:
- DATA_BITS, 8, width of one UART word.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- START_TIMEOUT, 64, clk cycles to wait for uart_tx_busy after a launch before abandoning the word; >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- mode  input  2  0=ECHO (drain), 1=HOLD (buffer, no drain), 2=DISCARD (ignore rx), 3=reserved, behaves as HOLD.
- clear_flags  input  1  one-cycle pulse; clears overflow and timeout_err.
- uart_rx_valid  input  1  one-cycle strobe, new word on uart_rx_data.
- uart_rx_data  input  DATA_BITS  received word.
- uart_rx_break  input  1  BREAK detected by the receiver.
- uart_tx_busy  input  1  transmitter busy.
- uart_tx_en  output  1  one-cycle launch strobe to the transmitter.
- uart_tx_data  output  DATA_BITS  word to transmit; stable from launch until the FSM returns to IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.
- timeout_err  output  1  sticky: a launch was not acknowledged by busy.

Behaviour:
- Reset values (asynchronous):
  - uart_tx_en=0, uart_tx_data=0, fifo_count=0, overflow=0, timeout_err=0.
  - Pointers=0; FSM=IDLE; timeout counter=0.
- Push:
  - Occurs on uart_rx_valid=1, mode!=DISCARD, no break.
  - If full and no pop in the same cycle: word dropped, overflow set next cycle.
  - If full with a simultaneous pop: push accepted, count unchanged.
- Break: uart_rx_break=1 flushes the FIFO (pointers and count to 0) next cycle.
  - Break has priority over push and pop in the same cycle.
  - A word already popped into uart_tx_data still completes.
- clear_flags clears overflow and timeout_err.
  - If a set event occurs in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH; count is tracked separately, so full = (count==FIFO_DEPTH).
- FSM IDLE:
  - Condition: mode==ECHO, count>0, uart_tx_busy=0.
  - Action: pop head into the uart_tx_data register, go to LAUNCH.
  - Pop latency: 1 cycle after the condition is true.
- FSM LAUNCH: uart_tx_en=1 for exactly this cycle; counter cleared; go to WAIT_BUSY.
- FSM WAIT_BUSY:
  - If uart_tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter; at START_TIMEOUT-1, set timeout_err and go to IDLE (word abandoned).
- FSM WAIT_DONE: when uart_tx_busy=0, go to IDLE.
- Minimum spacing between consecutive launches: 3 cycles plus transmitter busy time.
- Mode changes:
  - Sampled only in IDLE; an in-flight word always completes.
  - HOLD retains contents; DISCARD retains contents but accepts no new pushes.
- Push into an empty FIFO: the word is visible to IDLE the next cycle (no fall-through in the same cycle).
- Reset mid-transfer: the FSM returns to IDLE immediately and uart_tx_en drops; the transmitter is reset on the same net.
- Widths: fifo_count saturates at FIFO_DEPTH by construction; no arithmetic overflow.

Decomposition:
- Shared package uart_pkg holds:
  - mode constants UART_MODE_ECHO=2'd0, UART_MODE_HOLD=2'd1, UART_MODE_DISCARD=2'd2;
  - FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE) as 2-bit localparams;
  - the helper for the fifo_count width.
- One sub-module, uart_sync_fifo:
  - parametrised by DATA_BITS and FIFO_DEPTH;
  - ports: push, pop, flush, wdata, rdata, count, full, empty;
  - same clk and reset.
- Flags and FSM live in uart_echo_buffer.

Test Plan:
- Echo:
  - Stimulus: mode=0; rx words 0x41, 0x42, 0x43; transmitter model asserts busy 1 cycle after tx_en and holds it 20 cycles.
  - Required: three tx_en pulses carrying 0x41, 0x42, 0x43 in order; fifo_count returns to 0; no flags.
- Hold then release:
  - Stimulus: mode=1; push 5 words 0x10..0x14; then mode=0.
  - Required: no tx_en while held; fifo_count=5; after release, 5 launches in order 0x10..0x14.
- Overflow:
  - Stimulus: mode=1, FIFO_DEPTH=16; push 18 words 0x00..0x11.
  - Required: fifo_count=16; overflow=1 after the 17th push; contents are 0x00..0x0F; clear_flags brings overflow to 0.
- Break flush:
  - Stimulus: mode=0, busy held high, 4 words queued; assert uart_rx_break together with rx_valid.
  - Required: fifo_count=0 next cycle; the simultaneous word is not stored; no further launches.
- Timeout:
  - Stimulus: mode=0; one word 0x5A; busy never asserts; START_TIMEOUT=64.
  - Required: a single tx_en carrying 0x5A; timeout_err=1 exactly 64 cycles after the launch cycle; FSM back in IDLE.
- Simultaneous push/pop at full plus reset:
  - Stimulus: full FIFO, pop and push in the same cycle.
  - Required: count stays 16, overflow=0.
  - Stimulus: then assert reset during WAIT_DONE.
  - Required: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART echo path.
// Holds the run-time mode codes, the echo FSM state encoding and the helper
// that sizes occupancy counters so that a completely full FIFO is
// representable.
package uart_pkg;

    localparam logic [1:0] UART_MODE_ECHO    = 2'd0;
    localparam logic [1:0] UART_MODE_HOLD    = 2'd1;
    localparam logic [1:0] UART_MODE_DISCARD = 2'd2;

    localparam logic [1:0] UART_ST_IDLE      = 2'd0;
    localparam logic [1:0] UART_ST_LAUNCH    = 2'd1;
    localparam logic [1:0] UART_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] UART_ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = UART_ST_IDLE,
        LAUNCH    = UART_ST_LAUNCH,
        WAIT_BUSY = UART_ST_WAIT_BUSY,
        WAIT_DONE = UART_ST_WAIT_DONE
    } uart_echo_state_e;

    // One extra bit so that count == depth fits.
    function automatic int uart_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO used as the echo queue.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   push, wdata     write request and word; ignored when full unless a pop
//                   happens in the same cycle
//   pop, rdata      read request; rdata always shows the head word
//   flush           empties the FIFO; wins over push and pop
//   count           occupancy, 0..FIFO_DEPTH
//   full, empty     occupancy status
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      push,
    input  logic                                      pop,
    input  logic                                      flush,
    input  logic [DATA_BITS-1:0]                      wdata,
    output logic [DATA_BITS-1:0]                      rdata,
    output logic [uart_count_width(FIFO_DEPTH)-1:0]   count,
    output logic                                      full,
    output logic                                      empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = uart_count_width(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot wr_ptr points at; the head is read before the write lands.
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered echo between a uart_rx and a uart_tx instance.
// Received words are queued and drained to the transmitter by a busy-aware
// handshake FSM, under run-time control of the mode input.
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   mode                        0 echo, 1 hold, 2 discard, 3 acts as hold
//   clear_flags                 pulse clearing overflow and timeout_err
//   uart_rx_valid/data/break    receiver strobe, word and BREAK indication
//   uart_tx_busy                transmitter busy
//   uart_tx_en, uart_tx_data    launch strobe and word held for the transfer
//   fifo_count                  queue occupancy
//   overflow, timeout_err       sticky error flags
//
// state     | meaning
// IDLE      | waiting for echo mode, a queued word and an idle transmitter
// LAUNCH    | uart_tx_en asserted for this single cycle
// WAIT_BUSY | waiting for the transmitter to acknowledge with busy
// WAIT_DONE | transmitter busy; waiting for it to finish
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [1:0]                                mode,
    input  logic                                      clear_flags,
    input  logic                                      uart_rx_valid,
    input  logic [DATA_BITS-1:0]                      uart_rx_data,
    input  logic                                      uart_rx_break,
    input  logic                                      uart_tx_busy,
    output logic                                      uart_tx_en,
    output logic [DATA_BITS-1:0]                      uart_tx_data,
    output logic [uart_count_width(FIFO_DEPTH)-1:0]   fifo_count,
    output logic                                      overflow,
    output logic                                      timeout_err
);

    localparam int TW = $clog2(START_TIMEOUT);

    uart_echo_state_e     state_q;
    uart_echo_state_e     state_d;
    logic [TW-1:0]        cnt_q;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 timeout_set;
    logic                 fifo_pop;
    logic                 push_req;
    logic                 overflow_set;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    assign push_req     = uart_rx_valid & (mode != UART_MODE_DISCARD) & ~uart_rx_break;
    assign overflow_set = push_req & fifo_full & ~fifo_pop;

    uart_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .flush (uart_rx_break),
        .wdata (uart_rx_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        uart_tx_en  = 1'b0;
        fifo_pop    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                // Break blocks the pop so the flush wins cleanly.
                if (mode == UART_MODE_ECHO && !fifo_empty && !uart_tx_busy && !uart_rx_break) begin
                    fifo_pop = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                uart_tx_en = 1'b1;
                cnt_clr    = 1'b1;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TW'(START_TIMEOUT - 2)) begin
                    // The increment in this cycle is the one that would reach
                    // START_TIMEOUT-1, so give up here.
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            uart_tx_data <= '0;
        end else begin
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + TW'(1);
            if (fifo_pop) uart_tx_data <= fifo_rdata;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overflow_set)     overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (timeout_set)      timeout_err <= 1'b1;
            else if (clear_flags) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
module tb_uart_echo_buffer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       clear_flags = 1'b0;
    logic       uart_rx_valid = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_break = 1'b0;
    logic       uart_tx_busy;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       timeout_err;

    int n_pass = 0;
    int n_chk  = 0;

    // Transmitter model controls
    bit tx_auto    = 1'b0;
    bit force_busy = 1'b0;
    int busy_len   = 20;
    int busy_left  = 0;
    bit launch_seen = 1'b0;

    logic [7:0] mon_q[$];
    logic [7:0] exp_q[$];

    uart_echo_buffer #(
        .DATA_BITS     (8),
        .FIFO_DEPTH    (16),
        .START_TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .clear_flags   (clear_flags),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_en    (uart_tx_en),
        .uart_tx_data  (uart_tx_data),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises one cycle after a launch and lasts busy_len
    // cycles; every launch is logged with its word.
    always @(negedge clk) begin
        if (reset) begin
            busy_left    = 0;
            launch_seen  = 1'b0;
            uart_tx_busy = 1'b0;
        end else begin
            if (launch_seen) begin
                busy_left   = busy_len;
                launch_seen = 1'b0;
            end
            if (busy_left > 0) begin
                uart_tx_busy = 1'b1;
                busy_left--;
            end else begin
                uart_tx_busy = force_busy;
            end
            if (uart_tx_en) begin
                mon_q.push_back(uart_tx_data);
                if (tx_auto) launch_seen = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [7:0] w);
        @(posedge clk); #1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = w;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk); #1;
        mode = m;
    endtask

    task automatic wait_launches(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && mon_q.size() < n; i++) @(negedge clk);
        chk(tag, mon_q.size(), n);
    endtask

    task automatic compare_stream(input string tag);
        logic [7:0] obs;
        while (exp_q.size() > 0) begin
            obs = (mon_q.size() > 0) ? mon_q.pop_front() : 8'hxx;
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [7:0] w;
        bit         ovf_model;
        bit         seen;
        int         n_rand;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx_en", uart_tx_en, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Echo three words
        mode = UART_MODE_ECHO;
        tx_auto = 1'b1;
        busy_len = 20;
        mon_q.delete();
        exp_q = {8'h41, 8'h42, 8'h43};
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        wait_launches("echo_launches", 3, 400);
        compare_stream("echo_word");
        repeat (30) @(negedge clk);
        chk("echo_count", fifo_count, 0);
        chk("echo_overflow", overflow, 0);
        chk("echo_timeout", timeout_err, 0);

        // Hold then release
        set_mode(UART_MODE_HOLD);
        mon_q.delete();
        for (int i = 0; i < 5; i++) begin
            w = 8'h10 + 8'(i);
            exp_q.push_back(w);
            push_word(w);
        end
        repeat (10) @(negedge clk);
        chk("hold_no_launch", mon_q.size(), 0);
        chk("hold_count", fifo_count, 5);
        set_mode(UART_MODE_ECHO);
        wait_launches("release_launches", 5, 600);
        compare_stream("release_word");
        repeat (30) @(negedge clk);
        chk("release_count", fifo_count, 0);

        // Overflow in hold mode
        set_mode(UART_MODE_HOLD);
        mon_q.delete();
        exp_q.delete();
        ovf_model = 1'b0;
        for (int i = 0; i < 18; i++) begin
            w = 8'(i);
            if (exp_q.size() < 16) exp_q.push_back(w);
            else ovf_model = 1'b1;
            push_word(w);
            chk("ovf_flag", overflow, ovf_model);
        end
        chk("ovf_count", fifo_count, 16);
        pulse_clear();
        chk("ovf_cleared", overflow, 0);
        busy_len = 2;
        set_mode(UART_MODE_ECHO);
        wait_launches("ovf_drain_launches", 16, 1000);
        compare_stream("ovf_contents");
        repeat (10) @(negedge clk);
        chk("ovf_drain_count", fifo_count, 0);

        // Break flush with transmitter held busy
        busy_len = 20;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        mon_q.delete();
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        chk("brk_pre_count", fifo_count, 4);
        @(posedge clk); #1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h99;
        uart_rx_break = 1'b1;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        chk("brk_count", fifo_count, 0);
        force_busy = 1'b0;
        repeat (60) @(negedge clk);
        chk("brk_no_launch", mon_q.size(), 0);
        chk("brk_count_after", fifo_count, 0);

        // Tx-start timeout: busy never comes
        tx_auto = 1'b0;
        mon_q.delete();
        push_word(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = uart_tx_en;
        end
        chk("to_launch_seen", seen, 1);
        chk("to_launch_data", uart_tx_data, 8'h5A);
        repeat (63) @(negedge clk);
        chk("to_flag_early", timeout_err, 0);
        @(negedge clk);
        chk("to_flag_at_64", timeout_err, 1);
        chk("to_single_launch", mon_q.size(), 1);
        // Back in IDLE: a fresh word is launched promptly
        push_word(8'h33);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = uart_tx_en;
        end
        chk("to_relaunch_seen", seen, 1);
        chk("to_relaunch_data", uart_tx_data, 8'h33);
        repeat (70) @(negedge clk);
        pulse_clear();
        chk("to_cleared", timeout_err, 0);

        // Full FIFO with simultaneous push and pop, then reset in WAIT_DONE
        tx_auto = 1'b1;
        busy_len = 20;
        set_mode(UART_MODE_HOLD);
        mon_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            exp_q.push_back(w);
            push_word(w);
        end
        chk("pp_full_count", fifo_count, 16);
        @(posedge clk); #1;
        mode = UART_MODE_ECHO;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hC3;
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        chk("pp_count", fifo_count, 16);
        chk("pp_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        chk("pp_first_word", (mon_q.size() > 0) ? mon_q[0] : 8'hxx, exp_q[0]);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx_en", uart_tx_en, 0);
        chk("mid_rst_tx_data", uart_tx_data, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomised echo against the in-order queue model
        mon_q.delete();
        exp_q.delete();
        busy_len = int'($urandom_range(1, 4));
        n_rand = 12;
        for (int i = 0; i < n_rand; i++) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            w = 8'($urandom);
            exp_q.push_back(w);
            push_word(w);
        end
        wait_launches("rand_launches", n_rand, 2000);
        compare_stream("rand_word");
        repeat (20) @(negedge clk);
        chk("rand_count", fifo_count, 0);
        chk("rand_overflow", overflow, 0);
        chk("rand_timeout", timeout_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
